// File: rtl/ex_sched_if.sv
// ex_sched_if: the bundle between the decoder/ALU side and the EX scheduler.
//   master : decoder + ALU + MAU side. Drives id_*, pc_load and mau_conflict.
//            Receives id_ready, ex_* and redirect.
//   slave  : ex_sched. Mirror image of master.
// CTRL_W sets the width of the decoded control bundle that is passed through
// to the ALU without being interpreted.
interface ex_sched_if #(
    parameter int CTRL_W = 64
);
    logic              id_valid;
    logic              id_ready;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_imm;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_rs1en;
    logic              id_rs2en;
    logic              id_rden;
    logic              id_load;

    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_pc;
    logic [4:0]        ex_rd;
    logic              ex_rden;
    logic [1:0]        ex_fwd1;
    logic [1:0]        ex_fwd2;

    logic              pc_load;
    logic              mau_conflict;
    logic              redirect;

    modport master (
        output id_valid, id_ctrl, id_imm, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1en, id_rs2en, id_rden, id_load, pc_load, mau_conflict,
        input  id_ready, ex_valid, ex_ctrl, ex_imm, ex_pc, ex_rd, ex_rden,
               ex_fwd1, ex_fwd2, redirect
    );

    modport slave (
        input  id_valid, id_ctrl, id_imm, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1en, id_rs2en, id_rden, id_load, pc_load, mau_conflict,
        output id_ready, ex_valid, ex_ctrl, ex_imm, ex_pc, ex_rd, ex_rden,
               ex_fwd1, ex_fwd2, redirect
    );
endinterface

// File: rtl/ex_sched.sv
// ex_sched: RV32I execute-stage scheduler.
// Owns the EX pipeline register feeding the combinational ALU, issues from the
// decoder with valid/ready, freezes on MAU conflicts, squashes wrong-path work
// on a taken branch/jump, inserts load-use bubbles, and registers forwarding
// selects (0 regfile, 1 MEM result, 2 WB result) alongside the instruction.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          ex_sched_if.slave: id_* in, id_ready out, ex_* out,
//                pc_load / mau_conflict in, redirect out
//   perf_stall   cycles with mau_conflict            (EX_SCHED_PERF_EN only)
//   perf_bubble  load-use bubbles inserted           (EX_SCHED_PERF_EN only)
//   perf_flush   redirects issued                    (EX_SCHED_PERF_EN only)
//
// Build option: define EX_SCHED_PERF_EN to add the three 32-bit counters.
module ex_sched (
    input  logic      clk,
    input  logic      reset,
    ex_sched_if.slave bus
`ifdef EX_SCHED_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_flush
`endif
);

    logic       ex_load;
    // MEM slot of the destination scoreboard. Only "will write rd" matters for
    // forwarding, so valid and rden are folded into one bit. The WB slot needs
    // no storage: the MEM slot seen at issue is exactly what sits in WB once
    // the consumer reaches EX, which is what a select of 2 means.
    logic       mem_wr;
    logic [4:0] mem_rd;

    logic       advance;
    logic       flush;
    logic       loaduse;
    logic       take;
    logic       ex_fwdable;
    logic [1:0] fwd1_nxt;
    logic [1:0] fwd2_nxt;

    assign advance = ~bus.mau_conflict;
    assign flush   = bus.ex_valid & bus.pc_load & advance;
    assign loaduse = bus.id_valid & bus.ex_valid & ex_load & bus.ex_rden &
                     (bus.ex_rd != 5'd0) &
                     ((bus.id_rs1en & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_rs2en & (bus.id_rs2 == bus.ex_rd)));

    // A flush consumes and drops the ID instruction, hence ready even when a
    // load-use hazard is also present. Ready is held low while in reset so
    // nothing is considered accepted.
    assign bus.id_ready = reset & advance & (flush | ~loaduse);
    assign bus.redirect = flush;

    assign take       = advance & ~flush & ~loaduse & bus.id_valid;
    // A load in EX has no result yet; that case is a load-use bubble instead.
    assign ex_fwdable = bus.ex_valid & bus.ex_rden & ~ex_load;

    function automatic logic [1:0] fwd_sel(
        input logic       en,
        input logic [4:0] rs,
        input logic       ex_ok,
        input logic [4:0] ex_rd,
        input logic       mem_ok,
        input logic [4:0] mem_rd_i
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (en && rs != 5'd0) begin
            if (ex_ok && ex_rd == rs) begin
                sel = 2'd1;
            end else if (mem_ok && mem_rd_i == rs) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd1_nxt = fwd_sel(bus.id_rs1en, bus.id_rs1, ex_fwdable, bus.ex_rd,
                           mem_wr, mem_rd);
        fwd2_nxt = fwd_sel(bus.id_rs2en, bus.id_rs2, ex_fwdable, bus.ex_rd,
                           mem_wr, mem_rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= '0;
            bus.ex_imm   <= '0;
            bus.ex_pc    <= '0;
            bus.ex_rd    <= '0;
            bus.ex_rden  <= 1'b0;
            bus.ex_fwd1  <= 2'd0;
            bus.ex_fwd2  <= 2'd0;
            ex_load      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_rd       <= '0;
        end else if (advance) begin
            // A flushing branch still retires into MEM.
            mem_wr <= bus.ex_valid & bus.ex_rden;
            mem_rd <= bus.ex_rd;
            if (take) begin
                bus.ex_valid <= 1'b1;
                bus.ex_ctrl  <= bus.id_ctrl;
                bus.ex_imm   <= bus.id_imm;
                bus.ex_pc    <= bus.id_pc;
                bus.ex_rd    <= bus.id_rd;
                bus.ex_rden  <= bus.id_rden;
                bus.ex_fwd1  <= fwd1_nxt;
                bus.ex_fwd2  <= fwd2_nxt;
                ex_load      <= bus.id_load;
            end else begin
                // Bubble: clear the payload too so squashed work never shows.
                bus.ex_valid <= 1'b0;
                bus.ex_ctrl  <= '0;
                bus.ex_imm   <= '0;
                bus.ex_pc    <= '0;
                bus.ex_rd    <= '0;
                bus.ex_rden  <= 1'b0;
                bus.ex_fwd1  <= 2'd0;
                bus.ex_fwd2  <= 2'd0;
                ex_load      <= 1'b0;
            end
        end
    end

`ifdef EX_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (bus.mau_conflict) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (advance && !flush && loaduse) begin
                perf_bubble <= perf_bubble + 32'd1;
            end
            if (flush) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule
